// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_adder.sv
// Combinational adder used for all sequential-PC arithmetic.
module fetch_unit_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    // Wraps modulo 2^W by construction
    assign sum = a + b;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, in-order response
// tagging, small decode buffer, and redirect handling that drains stale
// responses still in flight.
module fetch_unit #(
    parameter int              XLEN     = fetch_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_next4;
    logic [XLEN-1:0] redirect_aligned;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nx;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_nx;
    logic [CW-1:0]   buf_count;
    logic [CW:0]     credit_used;
    logic [PW-1:0]   tag_wr;
    logic [PW-1:0]   tag_rd;
    logic [PW-1:0]   buf_wr;
    logic [PW-1:0]   buf_rd;
    logic [XLEN-1:0] tag_q [DEPTH];
    fetch_entry_t    buf_q [DEPTH];
    logic            req_fire;
    logic            rsp_fire;
    logic            push;
    logic            pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Requests and buffered entries share one credit pool of DEPTH slots,
    // so a response always has somewhere to land.
    assign credit_used      = {1'b0, outstanding} + {1'b0, buf_count};
    assign imem_req_valid   = (state != ST_IDLE) && (credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
    assign imem_req_addr    = pc;
    assign req_fire         = imem_req_valid && imem_req_ready;
    assign rsp_fire         = imem_rsp_valid && (outstanding != '0);
    assign push             = rsp_fire && (drop_cnt == '0) && !redirect_valid;
    assign pop              = instr_valid && instr_ready;
    assign instr_valid      = (buf_count != '0);
    assign instr_data       = buf_q[buf_rd].instr;
    assign instr_pc         = buf_q[buf_rd].pc;
    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign outstanding_nx   = outstanding + CW'(req_fire) - CW'(rsp_fire);

    fetch_unit_adder #(.W(XLEN)) u_pc_add (
        .a   (pc),
        .b   (XLEN'(4)),
        .sum (pc_next4)
    );

    fetch_unit_adder #(.W(XLEN)) u_plus4_add (
        .a   (instr_pc),
        .b   (XLEN'(4)),
        .sum (instr_pc_plus4)
    );

    // Every response still in flight at a redirect belongs to the old stream
    always_comb begin
        drop_nx = drop_cnt;
        if (redirect_valid) begin
            drop_nx = outstanding_nx;
        end else if (rsp_fire && (drop_cnt != '0)) begin
            drop_nx = drop_cnt - 1'b1;
        end
    end

    // Control state: FSM, PC, credit counters and queue pointers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            buf_count   <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            buf_wr      <= '0;
            buf_rd      <= '0;
        end else begin
            if (state == ST_IDLE) begin
                state <= ST_FETCH;
            end else begin
                state <= (drop_nx != '0) ? ST_DRAIN : ST_FETCH;
            end

            if (redirect_valid) begin
                pc <= redirect_aligned;
            end else if (req_fire) begin
                pc <= pc_next4;
            end

            outstanding <= outstanding_nx;
            drop_cnt    <= drop_nx;

            if (req_fire) tag_wr <= ptr_inc(tag_wr);
            if (rsp_fire) tag_rd <= ptr_inc(tag_rd);

            if (redirect_valid) begin
                buf_count <= '0;
                buf_wr    <= '0;
                buf_rd    <= '0;
            end else begin
                buf_count <= buf_count + CW'(push) - CW'(pop);
                if (push) buf_wr <= ptr_inc(buf_wr);
                if (pop)  buf_rd <= ptr_inc(buf_rd);
            end
        end
    end

    // Tag queue and instruction buffer storage carry no reset
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_q[tag_wr] <= pc;
        end
        if (push) begin
            buf_q[buf_wr] <= '{instr: imem_rsp_data, pc: tag_q[tag_rd]};
        end
    end

    // Conditions the credit scheme must rule out
    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (!(push && (buf_count == CW'(DEPTH))));
            assert (!(imem_rsp_valid && (outstanding == '0)));
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-1 in-order memory model.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    logic [31:0] pend[$];
    logic [31:0] acc[$];
    logic [31:0] dlv[$];
    logic        rsp_en;
    int          n_checks = 0;
    int          n_fail = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One clock: record handshakes mid-cycle, then drive the memory response
    task automatic tick();
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            pend.push_back(imem_req_addr);
            acc.push_back(imem_req_addr);
        end
        if (instr_valid && instr_ready) begin
            dlv.push_back(instr_pc);
            check("pop_data", instr_data, instr_pc ^ K);
        end
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        if (rsp_en && pend.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = pend.pop_front() ^ K;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #2;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        pend.delete();
        acc.delete();
        dlv.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #2;
    endtask

    initial begin
        reset_n        = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        rsp_en         = 1'b1;
        #12;
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_instr_valid", instr_valid, 0);

        // Basic streaming, decode always ready
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        do_reset();
        check("idle_req_valid", imem_req_valid, 0);
        tick();
        check("t1_req_valid", imem_req_valid, 1);
        check("t1_req_addr", imem_req_addr, 32'h0);
        check("t1_instr_valid", instr_valid, 0);
        tick();
        check("t2_instr_valid", instr_valid, 0);
        check("t2_req_addr", imem_req_addr, 32'h4);
        tick();
        check("t3_instr_valid", instr_valid, 1);
        check("t3_instr_pc", instr_pc, 32'h0);
        check("t3_pc_plus4", instr_pc_plus4, 32'h4);
        check("t3_instr_data", instr_data, K);
        check("t3_credit_stall", imem_req_valid, 0);
        tick();
        check("t4_instr_pc", instr_pc, 32'h4);
        check("t4_req_addr", imem_req_addr, 32'h8);
        tick();
        check("t5_instr_valid", instr_valid, 0);
        check("t5_acc_count", acc.size(), 3);
        check("t5_acc0", acc[0], 32'h0);
        check("t5_acc1", acc[1], 32'h4);
        check("t5_acc2", acc[2], 32'h8);

        // Decode stalled: only DEPTH requests may issue
        instr_ready = 1'b0;
        do_reset();
        repeat (12) tick();
        check("stall_acc_count", acc.size(), 2);
        check("stall_req_valid", imem_req_valid, 0);
        check("stall_instr_valid", instr_valid, 1);
        check("stall_instr_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("pop_instr_pc", instr_pc, 32'h4);
        check("pop_req_valid", imem_req_valid, 1);
        check("pop_req_addr", imem_req_addr, 32'h8);
        repeat (3) tick();
        check("full_instr_valid", instr_valid, 1);

        // Asynchronous reset with a full buffer; stray responses ignored
        reset_n = 1'b0;
        #1;
        check("arst_instr_valid", instr_valid, 0);
        check("arst_req_valid", imem_req_valid, 0);
        pend.delete();
        acc.delete();
        dlv.delete();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        @(posedge clk);
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        reset_n        = 1'b1;
        #2;
        tick();
        check("arst_restart_valid", imem_req_valid, 1);
        check("arst_restart_addr", imem_req_addr, 32'h0);
        check("arst_restart_instr", instr_valid, 0);

        // Redirect with two outstanding requests
        rsp_en = 1'b0;
        do_reset();
        repeat (3) tick();
        check("rd_out2_req_valid", imem_req_valid, 0);
        check("rd_acc_count", acc.size(), 2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        rsp_en         = 1'b1;
        tick();
        check("rd_t4_req_valid", imem_req_valid, 0);
        check("rd_t4_instr_valid", instr_valid, 0);
        tick();
        check("rd_t5_req_valid", imem_req_valid, 1);
        check("rd_t5_req_addr", imem_req_addr, 32'h100);
        tick();
        check("rd_t6_instr_valid", instr_valid, 0);
        tick();
        check("rd_t7_instr_valid", instr_valid, 1);
        check("rd_t7_instr_pc", instr_pc, 32'h100);
        check("rd_t7_pc_plus4", instr_pc_plus4, 32'h104);
        check("rd_t7_instr_data", instr_data, 32'h100 ^ K);
        instr_ready = 1'b1;
        tick();
        check("rd_t8_instr_pc", instr_pc, 32'h104);
        check("rd_first_dlv", dlv[0], 32'h100);
        check("rd_acc2", acc[2], 32'h100);

        // Second redirect while draining
        rsp_en = 1'b0;
        do_reset();
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        tick();
        rsp_en = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        check("dr_req_valid", imem_req_valid, 1);
        check("dr_req_addr", imem_req_addr, 32'h200);
        tick();
        check("dr_t7_instr_valid", instr_valid, 0);
        tick();
        check("dr_t8_instr_valid", instr_valid, 1);
        check("dr_t8_instr_pc", instr_pc, 32'h200);
        repeat (8) tick();
        check("dr_dlv_enough", dlv.size() >= 3, 1);
        for (int i = 0; i < 3; i++) begin
            check("dr_dlv_stream", dlv[i], 32'h200 + 32'(4 * i));
        end
        check("dr_acc2", acc[2], 32'h200);

        // Hold while not accepted, then PC wrap at the top of the address space
        imem_req_ready = 1'b0;
        do_reset();
        tick();
        check("wr_t1_addr", imem_req_addr, 32'h0);
        tick();
        check("wr_hold_valid", imem_req_valid, 1);
        check("wr_hold_addr", imem_req_addr, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        tick();
        check("wr_t3_valid", imem_req_valid, 1);
        check("wr_t3_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        tick();
        check("wr_t4_addr", imem_req_addr, 32'h0);
        tick();
        check("wr_t5_instr_valid", instr_valid, 1);
        check("wr_t5_instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("wr_t5_pc_plus4", instr_pc_plus4, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
